seq_multiply: RTL and testbench
===============================

SEQ_MULTIPLY -- requirements
Module: seq_multiply

Interface
REQ-001 Parameter Q_BITS, default 10: number of fractional bits in both operands and in the result.
REQ-002 Parameter D_WIDTH, default 32: width of the operands and the result.
REQ-003 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low.
REQ-005 Port multiplicand, input, D_WIDTH, signed Q(D_WIDTH-Q_BITS).Q_BITS operand.
REQ-006 Port multiplier, input, D_WIDTH, signed Q-format operand.
REQ-007 Port valid_in, input, 1: operands valid this cycle.
REQ-008 Port ready, output, 1: high only in IDLE; operands are accepted on a rising edge where valid_in and ready are both high.
REQ-009 Port product, output, D_WIDTH, signed Q-format result, registered.
REQ-010 Port valid_out, output, 1: product valid; single-cycle pulse.
REQ-011 Port overflow, output, 1: result exceeded range; qualified by valid_out.

Function
REQ-012 FSM states: IDLE, MUL, DONE. Transitions: IDLE->MUL on accept; MUL->DONE after exactly D_WIDTH iterations; DONE->IDLE unconditionally after one cycle.
REQ-013 On accept: register sign = sign(multiplicand) XOR sign(multiplier). Register both magnitudes as D_WIDTH-bit unsigned values. Clear the 2*D_WIDTH-bit accumulator and the iteration counter.
REQ-014 The most-negative input (-2^(D_WIDTH-1)) has magnitude 2^(D_WIDTH-1) and is handled exactly, with no wrap of the magnitude.
REQ-015 Each MUL cycle performs one shift-add step: examine the next multiplier bit, LSB first; if the bit is 1, add the shifted multiplicand magnitude to the accumulator. The counter increments by 1 per cycle.
REQ-016 On entering DONE, form the rounded magnitude as (accumulator + 2^(Q_BITS-1)) >> Q_BITS. This is round-half-up on the magnitude, giving symmetric rounding for signed results.
REQ-017 On entering DONE, product is set as follows. If sign=1 and the rounded magnitude is nonzero, product = negated magnitude. Otherwise product = magnitude. A negative zero is never produced.
REQ-018 Latency: valid_out rises exactly D_WIDTH+1 rising edges after the accept edge. valid_out is high for exactly one cycle. product and overflow hold their values until the next DONE.
REQ-019 valid_in is ignored while ready=0. No operand is buffered, and held operands are not re-accepted until IDLE.
REQ-020 Throughput: one operation per D_WIDTH+2 cycles. A valid_in held high continuously re-accepts on the first IDLE cycle.
REQ-021 Range check: overflow is set when the signed result is greater than 2^(D_WIDTH-1)-1 or less than -2^(D_WIDTH-1).

Reset
REQ-022 reset low asynchronously forces: state=IDLE, product=0, valid_out=0, overflow=0, counter=0, accumulator=0. ready rises in the first cycle after reset is released.
REQ-023 Reset asserted during MUL or DONE aborts the operation. No valid_out is issued for the aborted operation.

Configuration
REQ-024 Macro SEQ_MULTIPLY_SATURATE_EN defined: on overflow, product saturates to 2^(D_WIDTH-1)-1 (positive result) or -2^(D_WIDTH-1) (negative result), and overflow=1.
REQ-025 Macro SEQ_MULTIPLY_SATURATE_EN undefined: product is the low D_WIDTH bits of the signed rounded result (wrap), and overflow is tied to 0.

Structure
REQ-026 A shared fixed-point package holds the FSM state enum, the Q_BITS and D_WIDTH defaults, and the constants FIX_MAX, FIX_MIN and FIX_HALF (2^(Q_BITS-1)). The divider and this block both import it.
REQ-027 One sub-module, fix_round_sat, performs the combinational round, negate and saturate/wrap from the accumulator and sign. The FSM and datapath stay in seq_multiply.

Verification (Q_BITS=10, D_WIDTH=32)
REQ-028 multiplicand=1536 (1.5), multiplier=2048 (2.0) -> product=3072, overflow=0, valid_out exactly 33 edges after accept.
REQ-029 multiplicand=-1536, multiplier=2048 -> product=-3072. multiplicand=-1536, multiplier=-2048 -> product=3072.
REQ-030 Rounding: 1*1 -> 0 (no negative zero for -1*1). 23*23 -> 1 (529+512=1041, >>10 = 1). 512*512 -> 256.
REQ-031 Overflow: 33553408*33553408 -> with SATURATE_EN: product=0x7FFFFFFF, overflow=1. Same operands with one negated -> product=0x80000000. Without SATURATE_EN: product = low 32 bits of the rounded signed result, overflow=0.
REQ-032 Edge cases:
- valid_in toggled during MUL -> no effect on the result.
- reset pulsed mid-MUL -> no valid_out; a subsequent operation computes correctly.
- -2^31 * 1024 -> product=-2^31, overflow=0.

Source files
------------

// File: rtl/seq_multiply_pkg.sv
// Shared fixed-point definitions: default Q-format sizing, saturation constants and the
// sequencer state encoding used by the multi-cycle arithmetic blocks.
package seq_multiply_pkg;

  localparam int Q_BITS_DEF  = 10;
  localparam int D_WIDTH_DEF = 32;

  localparam logic [D_WIDTH_DEF-1:0] FIX_MAX  = {1'b0, {(D_WIDTH_DEF-1){1'b1}}};
  localparam logic [D_WIDTH_DEF-1:0] FIX_MIN  = {1'b1, {(D_WIDTH_DEF-1){1'b0}}};
  localparam logic [D_WIDTH_DEF-1:0] FIX_HALF = D_WIDTH_DEF'(1) << (Q_BITS_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiply_if.sv
// Operand/result handshake bundle for seq_multiply; master drives operands, slave returns the product.
interface seq_multiply_if #(
  parameter int D_WIDTH = 32
);
  logic signed [D_WIDTH-1:0] multiplicand;
  logic signed [D_WIDTH-1:0] multiplier;
  logic                      valid_in;
  logic                      ready;
  logic signed [D_WIDTH-1:0] product;
  logic                      valid_out;
  logic                      overflow;

  modport master (
    output multiplicand, multiplier, valid_in,
    input  ready, product, valid_out, overflow
  );

  modport slave (
    input  multiplicand, multiplier, valid_in,
    output ready, product, valid_out, overflow
  );
endinterface

// File: rtl/fix_round_sat.sv
// Round-half-up on the accumulator magnitude, re-apply sign, then saturate or wrap.
// Build macro SEQ_MULTIPLY_SATURATE_EN selects saturation; otherwise the result wraps and overflow is 0.
module fix_round_sat #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input  logic [2*D_WIDTH-1:0] acc,
  input  logic                 sign,
  output logic [D_WIDTH-1:0]   product,
  output logic                 overflow
);
  localparam int AW = 2 * D_WIDTH;
  localparam logic [AW-1:0] HALF = AW'(1) << (Q_BITS - 1);

  logic [AW-1:0]      mag;
  logic [D_WIDTH-1:0] mag_lo;
  logic [D_WIDTH-1:0] wrapped;
  logic               negative;

  // acc never exceeds 2^(2*D_WIDTH-2), so adding HALF cannot carry out
  assign mag      = (acc + HALF) >> Q_BITS;
  assign mag_lo   = mag[D_WIDTH-1:0];
  assign negative = sign && (mag != '0);
  assign wrapped  = negative ? (~mag_lo + D_WIDTH'(1)) : mag_lo;

`ifdef SEQ_MULTIPLY_SATURATE_EN
  localparam logic [AW-1:0]      NEG_LIM = AW'(1) << (D_WIDTH - 1);
  localparam logic [AW-1:0]      POS_LIM = NEG_LIM - AW'(1);
  localparam logic [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

  logic too_big;

  // negative side reaches one step further: -2^(D_WIDTH-1) is representable
  assign too_big  = sign ? (mag > NEG_LIM) : (mag > POS_LIM);
  assign overflow = too_big;
  assign product  = too_big ? (sign ? SAT_MIN : SAT_MAX) : wrapped;
`else
  logic unused_mag_hi;

  assign unused_mag_hi = ^mag[AW-1:D_WIDTH];
  assign overflow      = 1'b0;
  assign product       = wrapped;
`endif

endmodule

// File: rtl/seq_multiply.sv
// Sequential shift-add signed Q-format multiplier, one multiplier bit per cycle.
// Build macro SEQ_MULTIPLY_SATURATE_EN enables saturation of out-of-range results.
//
// state   | meaning
// ST_IDLE | ready high, waiting for valid_in
// ST_MUL  | one shift-add step per cycle, D_WIDTH cycles
// ST_DONE | rounded result captured, valid_out pulses on the following cycle
module seq_multiply
  import seq_multiply_pkg::*;
#(
  parameter int Q_BITS  = Q_BITS_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input logic           clock,
  input logic           reset,
  seq_multiply_if.slave bus
);
  localparam int CNT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_WIDTH - 1);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [2*D_WIDTH-1:0] acc;
  logic [2*D_WIDTH-1:0] mcand_sh;
  logic [D_WIDTH-1:0]   mplier_sh;
  logic [D_WIDTH-1:0]   mag_a;
  logic [D_WIDTH-1:0]   mag_b;
  logic                 sign;
  logic                 ready;
  logic                 accept;
  logic [D_WIDTH-1:0]   product;
  logic                 valid_out;
  logic                 overflow;
  logic [D_WIDTH-1:0]   rs_product;
  logic                 rs_overflow;

  // unsigned magnitude keeps -2^(D_WIDTH-1) exact as 2^(D_WIDTH-1)
  assign mag_a = bus.multiplicand[D_WIDTH-1] ? (~bus.multiplicand + D_WIDTH'(1)) : bus.multiplicand;
  assign mag_b = bus.multiplier[D_WIDTH-1]   ? (~bus.multiplier + D_WIDTH'(1))   : bus.multiplier;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.valid_in) state_nx = ST_MUL;
      end
      ST_MUL: begin
        if (cnt == CNT_LAST) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign accept = ready && bus.valid_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      sign      <= 1'b0;
      product   <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sign      <= bus.multiplicand[D_WIDTH-1] ^ bus.multiplier[D_WIDTH-1];
            mcand_sh  <= {{D_WIDTH{1'b0}}, mag_a};
            mplier_sh <= mag_b;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        ST_MUL: begin
          if (mplier_sh[0]) acc <= acc + mcand_sh;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_sh >> 1;
          cnt       <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          product   <= rs_product;
          overflow  <= rs_overflow;
          valid_out <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  fix_round_sat #(
    .Q_BITS  (Q_BITS),
    .D_WIDTH (D_WIDTH)
  ) u_round (
    .acc      (acc),
    .sign     (sign),
    .product  (rs_product),
    .overflow (rs_overflow)
  );

  assign bus.ready     = ready;
  assign bus.product   = product;
  assign bus.valid_out = valid_out;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_seq_multiply.sv
// Randomized bench for seq_multiply (Q_BITS=10, D_WIDTH=32) against an arithmetic model with
// per-cycle checks of ready, valid_out timing, product and overflow.
module tb_seq_multiply;

  typedef struct {
    longint      edge_no;
    logic [31:0] p;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        ov;
  } lit_t;

  logic   clock;
  logic   reset;
  longint cyc;
  int     n_checks;
  int     n_pass;
  exp_t   q[$];
  lit_t   lits[$];
  logic [31:0] last_p;
  logic        last_ov;

  seq_multiply_if #(.D_WIDTH(32)) bus ();

  seq_multiply #(
    .Q_BITS  (10),
    .D_WIDTH (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // exact product, round-half-up on magnitude, sign re-applied, then range handling
  function automatic void model(input logic signed [31:0] a, input logic signed [31:0] b,
                                output logic [31:0] p, output logic ov);
    longint ex, mg, r, res;
    ex  = longint'(a) * longint'(b);
    mg  = (ex < 0) ? -ex : ex;
    r   = (mg + 512) >>> 10;
    res = (ex < 0) ? -r : r;
    ov  = 1'b0;
`ifdef SEQ_MULTIPLY_SATURATE_EN
    if (res > 64'sd2147483647) begin
      p  = 32'h7FFF_FFFF;
      ov = 1'b1;
    end else if (res < -64'sd2147483648) begin
      p  = 32'h8000_0000;
      ov = 1'b1;
    end else begin
      p = res[31:0];
    end
`else
    p = res[31:0];
`endif
  endfunction

  // per-cycle compare, sampled mid-cycle away from the active edge
  always @(negedge clock) begin
    exp_t e;
    logic busy, exp_vo;
    logic [31:0] mp;
    logic mov;
    if (!reset) begin
      q.delete();
      chk("reset_outputs", {31'd0, bus.valid_out, bus.overflow, bus.product}, 64'd0);
    end else begin
      busy   = (q.size() > 0) && (cyc <= q[0].edge_no + 32);
      exp_vo = (q.size() > 0) && (cyc == q[0].edge_no + 33);
      chk("ready", {63'd0, bus.ready}, {63'd0, !busy});
      if (bus.valid_out || exp_vo)
        chk("valid_out", {63'd0, bus.valid_out}, {63'd0, exp_vo});
      if (exp_vo) begin
        e = q.pop_front();
        chk("product", {32'd0, bus.product}, {32'd0, e.p});
        chk("overflow", {63'd0, bus.overflow}, {63'd0, e.ov});
        last_p  = bus.product;
        last_ov = bus.overflow;
      end
      if (bus.valid_in && bus.ready) begin
        model(bus.multiplicand, bus.multiplier, mp, mov);
        e.edge_no = cyc + 1;
        e.p       = mp;
        e.ov      = mov;
        q.push_back(e);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    chk("result_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.valid_in     = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {63'd0, bus.ready}, 64'd1);
    @(posedge clock); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit toggle);
    start_op(a, b);
    if (toggle) begin
      for (int i = 0; i < 20; i++) begin
        bus.valid_in     = 1'($urandom_range(0, 1));
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        @(posedge clock); #1;
      end
      bus.valid_in = 1'b0;
    end
    wait_idle();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic [31:0] specials [7];
    specials = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd512, 32'h01FF_FC00};
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 4095));
      1:       v = $urandom;
      2:       v = 32'($urandom_range(0, 1 << 20));
      default: v = specials[$urandom_range(0, 6)];
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    lit_t l;
    logic [31:0] mp;
    logic mov;
    n_checks = 0;
    n_pass   = 0;
    reset            = 1'b0;
    bus.valid_in     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    lits.push_back('{32'd1536, 32'd2048, 32'd3072, 1'b0});
    lits.push_back('{32'hFFFF_FA00, 32'd2048, 32'hFFFF_F400, 1'b0});
    lits.push_back('{32'hFFFF_FA00, 32'hFFFF_F800, 32'd3072, 1'b0});
    lits.push_back('{32'd1, 32'd1, 32'd0, 1'b0});
    lits.push_back('{32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
    lits.push_back('{32'd23, 32'd23, 32'd1, 1'b0});
    lits.push_back('{32'd512, 32'd512, 32'd256, 1'b0});
    lits.push_back('{32'h8000_0000, 32'd1024, 32'h8000_0000, 1'b0});
`ifdef SEQ_MULTIPLY_SATURATE_EN
    lits.push_back('{32'd33553408, 32'd33553408, 32'h7FFF_FFFF, 1'b1});
    lits.push_back('{32'hFE00_0400, 32'd33553408, 32'h8000_0000, 1'b1});
`else
    lits.push_back('{32'd33553408, 32'd33553408, 32'hFC00_0400, 1'b0});
    lits.push_back('{32'hFE00_0400, 32'd33553408, 32'h03FF_FC00, 1'b0});
`endif

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    foreach (lits[i]) begin
      l = lits[i];
      model(l.a, l.b, mp, mov);
      chk($sformatf("model_lit%0d_p", i), {32'd0, mp}, {32'd0, l.p});
      chk($sformatf("model_lit%0d_ov", i), {63'd0, mov}, {63'd0, l.ov});
      last_p  = 'x;
      last_ov = 1'bx;
      op(l.a, l.b, (i == 0));
      chk($sformatf("dut_lit%0d_p", i), {32'd0, last_p}, {32'd0, l.p});
      chk($sformatf("dut_lit%0d_ov", i), {63'd0, last_ov}, {63'd0, l.ov});
    end

    // reset during MUL: no result may appear, next operation must be clean
    start_op(32'd1536, 32'd2048);
    repeat (10) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
    end
    last_p = 'x;
    op(32'd512, 32'd512, 1'b0);
    chk("after_abort_p", {32'd0, last_p}, 64'd256);

    // held valid_in re-accepts on each first IDLE cycle
    bus.multiplicand = 32'hFFFF_FA00;
    bus.multiplier   = 32'd2048;
    bus.valid_in     = 1'b1;
    repeat (3 * 34 + 5) begin
      @(posedge clock); #1;
    end
    bus.valid_in = 1'b0;
    wait_idle();

    for (int k = 0; k < 150; k++)
      op(rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
